vga_timing_gen: RTL

- Generates VGA raster timing for the display path: pixel-enable strobe `count`, 11-bit `hcounter`/`vcounter`, `blank`, `hsync` and `vsync`.
- Drives the pixel-output stage, which samples `hcounter`, `vcounter` and `blank` whenever `count` is high.
- Defaults give 640x480 @ 60 Hz from a 50 MHz `pixel_clk` divided by 2.

---
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, h/v position counters, registered blank and syncs.
// Define VGA_TIMING_FRAME_TICK_EN to add the frame_tick / frame_count outputs.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int CLK_DIV   = 2
) (
   input  logic        pixel_clk,
   input  logic        reset,
   output logic        count,
   output logic [10:0] hcounter,
   output logic [10:0] vcounter,
   output logic        blank,
   output logic        hsync,
   output logic        vsync
`ifdef VGA_TIMING_FRAME_TICK_EN
   ,
   output logic        frame_tick,
   output logic [7:0]  frame_count
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_VIS        = 11'(H_VISIBLE);
   localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_VIS        = 11'(V_VISIBLE);
   localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
   localparam logic [3:0]  DIV_LAST     = 4'(CLK_DIV - 1);

   typedef enum logic [1:0] {H_ST_ACTIVE, H_ST_FRONT, H_ST_SYNC, H_ST_BACK} h_state_t;
   typedef enum logic [1:0] {V_ST_ACTIVE, V_ST_FRONT, V_ST_SYNC, V_ST_BACK} v_state_t;

   logic [3:0]  div_cnt_q, div_cnt_d;
   logic        count_q, count_d;
   logic [10:0] hcounter_q, hcounter_d;
   logic [10:0] vcounter_q, vcounter_d;
   logic        blank_q, blank_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   h_state_t    h_state_q, h_state_d;
   v_state_t    v_state_q, v_state_d;

   always_comb begin
      div_cnt_d  = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
      count_d    = (div_cnt_q == DIV_LAST);
      hcounter_d = hcounter_q;
      vcounter_d = vcounter_q;
      h_state_d  = h_state_q;
      v_state_d  = v_state_q;

      // Region boundaries are detected on the next counter value so the
      // registered flags line up with the position they describe; every
      // porch and sync width is assumed to be at least one.
      if (count_q) begin
         if (hcounter_q == H_LAST) begin
            hcounter_d = 11'd0;
            vcounter_d = (vcounter_q == V_LAST) ? 11'd0 : vcounter_q + 11'd1;
            case (v_state_q)
               V_ST_ACTIVE: if (vcounter_d == V_VIS)        v_state_d = V_ST_FRONT;
               V_ST_FRONT:  if (vcounter_d == V_SYNC_START) v_state_d = V_ST_SYNC;
               V_ST_SYNC:   if (vcounter_d == V_SYNC_END)   v_state_d = V_ST_BACK;
               V_ST_BACK:   if (vcounter_d == 11'd0)        v_state_d = V_ST_ACTIVE;
               default:                                     v_state_d = V_ST_ACTIVE;
            endcase
         end else begin
            hcounter_d = hcounter_q + 11'd1;
         end
         case (h_state_q)
            H_ST_ACTIVE: if (hcounter_d == H_VIS)        h_state_d = H_ST_FRONT;
            H_ST_FRONT:  if (hcounter_d == H_SYNC_START) h_state_d = H_ST_SYNC;
            H_ST_SYNC:   if (hcounter_d == H_SYNC_END)   h_state_d = H_ST_BACK;
            H_ST_BACK:   if (hcounter_d == 11'd0)        h_state_d = H_ST_ACTIVE;
            default:                                     h_state_d = H_ST_ACTIVE;
         endcase
      end

      blank_d = (h_state_d != H_ST_ACTIVE) || (v_state_d != V_ST_ACTIVE);
      hsync_d = (h_state_d != H_ST_SYNC);
      vsync_d = (v_state_d != V_ST_SYNC);
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         div_cnt_q  <= 4'd0;
         count_q    <= 1'b0;
         hcounter_q <= 11'd0;
         vcounter_q <= 11'd0;
         blank_q    <= 1'b0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         h_state_q  <= H_ST_ACTIVE;
         v_state_q  <= V_ST_ACTIVE;
      end else begin
         div_cnt_q  <= div_cnt_d;
         count_q    <= count_d;
         hcounter_q <= hcounter_d;
         vcounter_q <= vcounter_d;
         blank_q    <= blank_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         h_state_q  <= h_state_d;
         v_state_q  <= v_state_d;
      end
   end

   assign count    = count_q;
   assign hcounter = hcounter_q;
   assign vcounter = vcounter_q;
   assign blank    = blank_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;

`ifdef VGA_TIMING_FRAME_TICK_EN
   logic       frame_tick_q, frame_tick_d;
   logic [7:0] frame_count_q, frame_count_d;

   // The tick is registered from next-cycle values so it coincides with the
   // last pixel's count strobe rather than trailing it.
   always_comb begin
      frame_tick_d  = count_d && (hcounter_d == H_LAST) && (vcounter_d == V_LAST);
      frame_count_d = frame_tick_q ? frame_count_q + 8'd1 : frame_count_q;
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         frame_tick_q  <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         frame_tick_q  <= frame_tick_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign frame_tick  = frame_tick_q;
   assign frame_count = frame_count_q;
`endif

endmodule
